// File: rtl/chip8_vga_pkg.sv
// Shared constants and types for the CHIP-8/SCHIP VGA display peripheral.
package chip8_vga_pkg;

    localparam int H_W = 11;
    localparam int V_W = 10;

    localparam int HACTIVE_DEF = 1280;
    localparam int HFRONT_DEF  = 32;
    localparam int HSYNC_DEF   = 192;
    localparam int HBACK_DEF   = 96;
    localparam int VACTIVE_DEF = 480;
    localparam int VFRONT_DEF  = 10;
    localparam int VSYNC_DEF   = 2;
    localparam int VBACK_DEF   = 33;

    localparam logic [3:0] REG_FG_R      = 4'd0;
    localparam logic [3:0] REG_FG_G      = 4'd1;
    localparam logic [3:0] REG_FG_B      = 4'd2;
    localparam logic [3:0] REG_BG_R      = 4'd3;
    localparam logic [3:0] REG_BG_G      = 4'd4;
    localparam logic [3:0] REG_BG_B      = 4'd5;
    localparam logic [3:0] REG_BORDER_R  = 4'd6;
    localparam logic [3:0] REG_BORDER_G  = 4'd7;
    localparam logic [3:0] REG_BORDER_B  = 4'd8;
    localparam logic [3:0] REG_MODE      = 4'd9;
    localparam logic [3:0] REG_STATUS    = 4'd10;
    localparam logic [3:0] REG_FRAME_CNT = 4'd11;

    localparam int MODE_HIRES  = 0;
    localparam int MODE_ENABLE = 1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/chip8_vga_timing.sv
// VGA line/frame counters with raw sync, blank and frame-event strobes.
module chip8_vga_timing
    import chip8_vga_pkg::*;
#(
    parameter int HACTIVE = HACTIVE_DEF,
    parameter int HFRONT  = HFRONT_DEF,
    parameter int HSYNC   = HSYNC_DEF,
    parameter int HBACK   = HBACK_DEF,
    parameter int VACTIVE = VACTIVE_DEF,
    parameter int VFRONT  = VFRONT_DEF,
    parameter int VSYNC   = VSYNC_DEF,
    parameter int VBACK   = VBACK_DEF
) (
    input  logic           clk,
    input  logic           reset,
    output logic [H_W-1:0] hcount,
    output logic [V_W-1:0] vcount,
    output logic           hs,
    output logic           vs,
    output logic           blank_n,
    output logic           vclk,
    output logic           frame_start,
    output logic           vblank_start
);

    localparam int HTOTAL = HACTIVE + HFRONT + HSYNC + HBACK;
    localparam int VTOTAL = VACTIVE + VFRONT + VSYNC + VBACK;

    logic h_last;
    assign h_last = (hcount == H_W'(HTOTAL - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (h_last) begin
            hcount <= '0;
            vcount <= (vcount == V_W'(VTOTAL - 1)) ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    // Strobes fire in the cycle before the counters land on the event position.
    assign frame_start  = h_last && (vcount == V_W'(VTOTAL - 1));
    assign vblank_start = h_last && (vcount == V_W'(VACTIVE - 1));

    assign hs = !((hcount >= H_W'(HACTIVE + HFRONT)) &&
                  (hcount <  H_W'(HACTIVE + HFRONT + HSYNC)));
    assign vs = !((vcount >= V_W'(VACTIVE + VFRONT)) &&
                  (vcount <  V_W'(VACTIVE + VFRONT + VSYNC)));
    assign blank_n = (hcount < H_W'(HACTIVE)) && (vcount < V_W'(VACTIVE));
    assign vclk    = hcount[0];

endmodule

// File: rtl/chip8_vga_display.sv
// Avalon-MM CHIP-8/SCHIP framebuffer scan-out to VGA with programmable colours,
// shadowed lores/hires mode and a vblank interrupt.
module chip8_vga_display
    import chip8_vga_pkg::*;
#(
    parameter int FB_COLS  = 128,
    parameter int FB_ROWS  = 64,
    parameter int SCALE_HI = 4,
    parameter int HACTIVE  = HACTIVE_DEF,
    parameter int HFRONT   = HFRONT_DEF,
    parameter int HSYNC    = HSYNC_DEF,
    parameter int HBACK    = HBACK_DEF,
    parameter int VACTIVE  = VACTIVE_DEF,
    parameter int VFRONT   = VFRONT_DEF,
    parameter int VSYNC    = VSYNC_DEF,
    parameter int VBACK    = VBACK_DEF,
    parameter int FB_AW    = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           chipselect,
    input  logic           write,
    input  logic           read,
    input  logic [FB_AW:0] address,
    input  logic [7:0]     writedata,
    output logic [7:0]     readdata,
    output logic           irq,
    output logic [7:0]     VGA_R,
    output logic [7:0]     VGA_G,
    output logic [7:0]     VGA_B,
    output logic           VGA_CLK,
    output logic           VGA_HS,
    output logic           VGA_VS,
    output logic           VGA_BLANK_n,
    output logic           VGA_SYNC_n
);

    localparam int STRIDE   = FB_COLS / 8;
    localparam int FB_BYTES = FB_COLS * FB_ROWS / 8;
    localparam int SH_HI    = $clog2(SCALE_HI);
    localparam int WIN_W    = FB_COLS * SCALE_HI;
    localparam int WIN_H    = FB_ROWS * SCALE_HI;
    localparam int COL_OFF  = (HACTIVE / 2 - WIN_W) / 2;
    localparam int ROW_OFF  = (VACTIVE - WIN_H) / 2;

    logic [H_W-1:0] hcount;
    logic [V_W-1:0] vcount;
    logic hs_raw, vs_raw, blank_n_raw, vclk_raw, frame_start, vblank_start;

    chip8_vga_timing #(
        .HACTIVE(HACTIVE), .HFRONT(HFRONT), .HSYNC(HSYNC), .HBACK(HBACK),
        .VACTIVE(VACTIVE), .VFRONT(VFRONT), .VSYNC(VSYNC), .VBACK(VBACK)
    ) u_timing (
        .clk(clk), .reset(reset),
        .hcount(hcount), .vcount(vcount),
        .hs(hs_raw), .vs(vs_raw), .blank_n(blank_n_raw), .vclk(vclk_raw),
        .frame_start(frame_start), .vblank_start(vblank_start)
    );

    logic             reg_sel;
    logic [3:0]       reg_idx;
    logic [FB_AW-1:0] fb_addr;
    logic             reg_wr, fb_wr, fb_rd;

    assign reg_sel = address[FB_AW];
    assign reg_idx = address[3:0];
    assign fb_addr = address[FB_AW-1:0];
    assign reg_wr  = chipselect && write && reg_sel;
    assign fb_wr   = chipselect && write && !reg_sel;
    assign fb_rd   = chipselect && read && !reg_sel;

    rgb_t       fg, bg, border;
    logic [1:0] mode_pending;
    logic       act_hires, act_enable;
    logic [7:0] frame_cnt;
    logic       in_vblank;

    assign in_vblank = (vcount >= V_W'(VACTIVE));

    // Mode writes are only shadowed here; the scan logic sees them at frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fg           <= rgb_t'(24'hFFFFFF);
            bg           <= rgb_t'(24'h000000);
            border       <= rgb_t'(24'h000080);
            mode_pending <= 2'b10;
            act_hires    <= 1'b0;
            act_enable   <= 1'b1;
            irq          <= 1'b0;
            frame_cnt    <= 8'h00;
        end else begin
            if (reg_wr) begin
                case (reg_idx)
                    REG_FG_R:     fg.r         <= writedata;
                    REG_FG_G:     fg.g         <= writedata;
                    REG_FG_B:     fg.b         <= writedata;
                    REG_BG_R:     bg.r         <= writedata;
                    REG_BG_G:     bg.g         <= writedata;
                    REG_BG_B:     bg.b         <= writedata;
                    REG_BORDER_R: border.r     <= writedata;
                    REG_BORDER_G: border.g     <= writedata;
                    REG_BORDER_B: border.b     <= writedata;
                    REG_MODE:     mode_pending <= writedata[1:0];
                    default:      ;
                endcase
            end
            if (frame_start) begin
                act_hires  <= mode_pending[MODE_HIRES];
                act_enable <= mode_pending[MODE_ENABLE];
            end
            if (vblank_start) begin
                irq       <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
            end else if (reg_wr && (reg_idx == REG_STATUS)) begin
                irq <= 1'b0;
            end
        end
    end

    logic [7:0] reg_rdata;

    always_comb begin
        reg_rdata = 8'h00;
        case (reg_idx)
            REG_FG_R:      reg_rdata = fg.r;
            REG_FG_G:      reg_rdata = fg.g;
            REG_FG_B:      reg_rdata = fg.b;
            REG_BG_R:      reg_rdata = bg.r;
            REG_BG_G:      reg_rdata = bg.g;
            REG_BG_B:      reg_rdata = bg.b;
            REG_BORDER_R:  reg_rdata = border.r;
            REG_BORDER_G:  reg_rdata = border.g;
            REG_BORDER_B:  reg_rdata = border.b;
            REG_MODE:      reg_rdata = {6'b0, mode_pending};
            REG_STATUS:    reg_rdata = {5'b0, act_hires, in_vblank, irq};
            REG_FRAME_CNT: reg_rdata = frame_cnt;
            default:       reg_rdata = 8'h00;
        endcase
    end

    logic [7:0] reg_q, cpu_q, scan_q;
    logic       rd_from_fb;

    // The RAM output register has no reset, so the holding mux picks the source.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_q      <= 8'h00;
            rd_from_fb <= 1'b0;
        end else if (chipselect && read) begin
            rd_from_fb <= !reg_sel;
            if (reg_sel) begin
                reg_q <= reg_rdata;
            end
        end
    end

    assign readdata = rd_from_fb ? cpu_q : reg_q;

    logic [9:0]       disp_x, disp_y, rel_x, rel_y, px, py;
    logic             in_window;
    logic [FB_AW-1:0] scan_addr;

    assign disp_x    = hcount[H_W-1:1];
    assign disp_y    = vcount;
    assign in_window = (disp_x >= 10'(COL_OFF)) && (disp_x < 10'(COL_OFF + WIN_W)) &&
                       (disp_y >= 10'(ROW_OFF)) && (disp_y < 10'(ROW_OFF + WIN_H));
    assign rel_x     = disp_x - 10'(COL_OFF);
    assign rel_y     = disp_y - 10'(ROW_OFF);
    assign px        = act_hires ? (rel_x >> SH_HI) : (rel_x >> (SH_HI + 1));
    assign py        = act_hires ? (rel_y >> SH_HI) : (rel_y >> (SH_HI + 1));
    assign scan_addr = FB_AW'(int'(py) * STRIDE + int'(px >> 3));

    logic [7:0] fb_mem [FB_BYTES];

    // CPU port and scan port share one clock; a colliding scan read sees old data.
    always_ff @(posedge clk) begin
        if (fb_wr) begin
            fb_mem[fb_addr] <= writedata;
        end
        if (fb_rd) begin
            cpu_q <= fb_mem[fb_addr];
        end
        scan_q <= fb_mem[scan_addr];
    end

    logic [2:0] s1_bit;
    logic       s1_show, s1_hs, s1_vs, s1_blank_n, s1_vclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_bit     <= 3'd0;
            s1_show    <= 1'b0;
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s1_blank_n <= 1'b0;
            s1_vclk    <= 1'b0;
        end else begin
            s1_bit     <= px[2:0];
            s1_show    <= in_window && act_enable;
            s1_hs      <= hs_raw;
            s1_vs      <= vs_raw;
            s1_blank_n <= blank_n_raw;
            s1_vclk    <= vclk_raw;
        end
    end

    rgb_t pix;

    always_comb begin
        pix = rgb_t'(24'h000000);
        if (!s1_blank_n) begin
            pix = rgb_t'(24'h000000);
        end else if (!s1_show) begin
            pix = border;
        end else if (scan_q[3'd7 - s1_bit]) begin
            pix = fg;
        end else begin
            pix = bg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_n <= 1'b0;
            VGA_CLK     <= 1'b0;
        end else begin
            VGA_R       <= pix.r;
            VGA_G       <= pix.g;
            VGA_B       <= pix.b;
            VGA_HS      <= s1_hs;
            VGA_VS      <= s1_vs;
            VGA_BLANK_n <= s1_blank_n;
            VGA_CLK     <= s1_vclk;
        end
    end

    assign VGA_SYNC_n = 1'b0;

endmodule

// File: tb/tb_chip8_vga_display.sv
// Directed bench for chip8_vga_display using a shrunken raster (16x8 hires fb,
// 48x24 display) so several whole frames fit in a short run.
module tb_chip8_vga_display;

    localparam int HA = 96, HF = 4, HS = 8, HB = 12;
    localparam int VA = 24, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [4:0] REG = 5'h10;

    logic       clk = 1'b0;
    logic       reset, chipselect, write, read;
    logic [4:0] address;
    logic [7:0] writedata, readdata;
    logic       irq;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    chip8_vga_display #(
        .FB_COLS(16), .FB_ROWS(8), .SCALE_HI(2),
        .HACTIVE(HA), .HFRONT(HF), .HSYNC(HS), .HBACK(HB),
        .VACTIVE(VA), .VFRONT(VF), .VSYNC(VS), .VBACK(VB),
        .FB_AW(4)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata), .irq(irq),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
    );

    always #10 clk = ~clk;

    // Edges since reset release; pins show the counter state from two edges earlier.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic cpu_read(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic wait_pos(input int v, input int h);
        int target = (v * HT + h + 2) % FRAME;
        int budget = 2 * FRAME;
        @(negedge clk);
        while ((cyc % FRAME) != target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++; fails++;
            $display("[TB] FAIL wait_pos(%0d,%0d): timed out, cyc=%0d", v, h, cyc);
        end
    endtask

    task automatic wait_mod(input int t);
        int budget = 2 * FRAME;
        @(negedge clk);
        while ((cyc % FRAME) != t && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++; fails++;
            $display("[TB] FAIL wait_mod(%0d): timed out", t);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin fails++; $display("[TB] FAIL reset_rgb: got %h want 000000", {VGA_R, VGA_G, VGA_B}); end
        checks++; if ({VGA_HS, VGA_VS} !== 2'b11) begin fails++; $display("[TB] FAIL reset_sync: got %b want 11", {VGA_HS, VGA_VS}); end
        checks++; if ({VGA_BLANK_n, VGA_CLK, VGA_SYNC_n} !== 3'b000) begin fails++; $display("[TB] FAIL reset_ctl: got %b want 000", {VGA_BLANK_n, VGA_CLK, VGA_SYNC_n}); end
        checks++; if ({irq, readdata} !== 9'h0) begin fails++; $display("[TB] FAIL reset_irq_rd: got %h want 000", {irq, readdata}); end
        reset = 1'b0;
    endtask

    task automatic test_timing();
        int budget = 1000;
        logic [7:0] d;
        @(negedge clk);
        while (VGA_HS !== 1'b0 && budget > 0) begin @(negedge clk); budget--; end
        checks++; if (cyc != HA + HF + 2) begin fails++; $display("[TB] FAIL first_hs_low: got cyc %0d want %0d", cyc, HA + HF + 2); end
        while (cyc != VA * HT - 1 && budget < 10000) begin @(negedge clk); budget++; end
        checks++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_before_vblank: got %b want 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_at_vblank: got %b want 1 (cyc %0d)", irq, cyc); end
        wait_pos(VA + VF - 1, 0);
        checks++; if (VGA_VS !== 1'b1) begin fails++; $display("[TB] FAIL vs_line25: got %b want 1", VGA_VS); end
        wait_pos(VA + VF, 0);
        checks++; if (VGA_VS !== 1'b0) begin fails++; $display("[TB] FAIL vs_line26: got %b want 0", VGA_VS); end
        wait_pos(VA + VF + 1, HT - 1);
        checks++; if (VGA_VS !== 1'b0) begin fails++; $display("[TB] FAIL vs_line27_end: got %b want 0", VGA_VS); end
        wait_pos(VA + VF + 2, 0);
        checks++; if (VGA_VS !== 1'b1) begin fails++; $display("[TB] FAIL vs_line28: got %b want 1", VGA_VS); end
        cpu_read(REG | 5'd11, d);
        checks++; if (d !== 8'd1) begin fails++; $display("[TB] FAIL frame_cnt_1: got %h want 01", d); end
        cpu_write(REG | 5'd10, 8'h00);
        checks++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_clear: got %b want 0", irq); end
        budget = 2 * FRAME;
        while (irq !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
        checks++; if (cyc != VA * HT + FRAME) begin fails++; $display("[TB] FAIL frame_period: irq at cyc %0d want %0d", cyc, VA * HT + FRAME); end
    endtask

    task automatic test_lores();
        for (int i = 0; i < 16; i++) cpu_write(5'(i), 8'h00);
        cpu_write(5'd0, 8'h80);
        wait_pos(4, 14);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h000080) begin fails++; $display("[TB] FAIL lores_border_x7: got %h want 000080", {VGA_R, VGA_G, VGA_B}); end
        wait_pos(4, 16);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin fails++; $display("[TB] FAIL lores_fg_x8: got %h want ffffff", {VGA_R, VGA_G, VGA_B}); end
        wait_pos(4, 24);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin fails++; $display("[TB] FAIL lores_bg_x12: got %h want 000000", {VGA_R, VGA_G, VGA_B}); end
        wait_pos(4, HA);
        checks++; if ({VGA_BLANK_n, VGA_R, VGA_G, VGA_B} !== 25'h0) begin fails++; $display("[TB] FAIL lores_hblank: got %b/%h want 0/000000", VGA_BLANK_n, {VGA_R, VGA_G, VGA_B}); end
        wait_pos(7, 22);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin fails++; $display("[TB] FAIL lores_fg_x11_y7: got %h want ffffff", {VGA_R, VGA_G, VGA_B}); end
        wait_pos(8, 16);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin fails++; $display("[TB] FAIL lores_bg_y8: got %h want 000000", {VGA_R, VGA_G, VGA_B}); end
    endtask

    task automatic test_hires();
        logic [7:0] d;
        wait_pos(2, 0);
        cpu_write(REG | 5'd9, 8'h03);
        cpu_read(REG | 5'd10, d);
        checks++; if (d[2] !== 1'b0) begin fails++; $display("[TB] FAIL status_hires_early: got %b want 0", d[2]); end
        wait_pos(4, 20);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin fails++; $display("[TB] FAIL still_lores_x10: got %h want ffffff", {VGA_R, VGA_G, VGA_B}); end
        wait_pos(VT - 1, 0);
        cpu_read(REG | 5'd10, d);
        checks++; if (d[2] !== 1'b0) begin fails++; $display("[TB] FAIL status_hires_lastline: got %b want 0", d[2]); end
        wait_pos(4, 18);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin fails++; $display("[TB] FAIL hires_fg_x9: got %h want ffffff", {VGA_R, VGA_G, VGA_B}); end
        wait_pos(4, 20);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin fails++; $display("[TB] FAIL hires_bg_x10: got %h want 000000", {VGA_R, VGA_G, VGA_B}); end
        wait_pos(6, 16);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin fails++; $display("[TB] FAIL hires_bg_y6: got %h want 000000", {VGA_R, VGA_G, VGA_B}); end
        cpu_read(REG | 5'd10, d);
        checks++; if (d[2] !== 1'b1) begin fails++; $display("[TB] FAIL status_hires_after: got %b want 1", d[2]); end
    endtask

    task automatic test_regs();
        logic [7:0] d;
        cpu_write(REG | 5'd6, 8'h12);
        cpu_read(REG | 5'd6, d);
        checks++; if (d !== 8'h12) begin fails++; $display("[TB] FAIL border_r_read: got %h want 12", d); end
        cpu_write(5'd5, 8'hA5);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 5'd5;
        #1;
        checks++; if (readdata !== 8'h12) begin fails++; $display("[TB] FAIL rd_hold_before_edge: got %h want 12", readdata); end
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        checks++; if (readdata !== 8'hA5) begin fails++; $display("[TB] FAIL fb5_read: got %h want a5", readdata); end
        repeat (3) @(negedge clk);
        checks++; if (readdata !== 8'hA5) begin fails++; $display("[TB] FAIL rd_hold_after: got %h want a5", readdata); end
        cpu_read(REG | 5'd13, d);
        checks++; if (d !== 8'h00) begin fails++; $display("[TB] FAIL reserved_reg: got %h want 00", d); end
        wait_pos(4, 14);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h120080) begin fails++; $display("[TB] FAIL new_border: got %h want 120080", {VGA_R, VGA_G, VGA_B}); end
    endtask

    task automatic test_irq_collision();
        cpu_write(REG | 5'd10, 8'h00);
        checks++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_pre_clear: got %b want 0", irq); end
        wait_mod(VA * HT - 1);
        chipselect = 1'b1; write = 1'b1; address = REG | 5'd10; writedata = 8'h01;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        checks++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_set_wins: got %b want 1", irq); end
        cpu_write(REG | 5'd10, 8'h00);
        checks++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_later_clear: got %b want 0", irq); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        wait_pos(12, 40);
        reset = 1'b1;
        #1;
        checks++; if ({VGA_R, VGA_G, VGA_B, VGA_BLANK_n, VGA_CLK} !== 26'h0) begin fails++; $display("[TB] FAIL midreset_rgb_ctl: got %h/%b%b want 0", {VGA_R, VGA_G, VGA_B}, VGA_BLANK_n, VGA_CLK); end
        checks++; if ({VGA_HS, VGA_VS, irq, readdata} !== 11'h600) begin fails++; $display("[TB] FAIL midreset_sync_irq_rd: got %h want 600", {VGA_HS, VGA_VS, irq, readdata}); end
        @(negedge clk);
        reset = 1'b0;
        cpu_read(5'd0, d);
        checks++; if (d !== 8'h80) begin fails++; $display("[TB] FAIL fb_kept: got %h want 80", d); end
        cpu_read(REG | 5'd6, d);
        checks++; if (d !== 8'h00) begin fails++; $display("[TB] FAIL border_r_reset: got %h want 00", d); end
        cpu_read(REG | 5'd10, d);
        checks++; if (d[2] !== 1'b0) begin fails++; $display("[TB] FAIL mode_reset: got %b want 0", d[2]); end
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0;
        test_reset();
        test_timing();
        test_lores();
        test_hires();
        test_regs();
        test_irq_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
